// File: rtl/snake_body_engine_if.sv
// Snake body engine bus: FSM action pulses, direction buttons, board status and display query.
// Latency: none (signal bundle only).
// Backpressure: none; every pulse is accepted in the cycle it is presented.
interface snake_body_engine_if #(
   parameter int XW = 4,
   parameter int YW = 4
);
   logic          first_do;
   logic          go_one_step;
   logic          eat_apple;
   logic          random_growth;
   logic [3:0]    dir_btn;
   logic [1:0]    head;
   logic [XW-1:0] head_x;
   logic [YW-1:0] head_y;
   logic [XW-1:0] apple_x;
   logic [YW-1:0] apple_y;
   logic          apple_valid;
   logic [5:0]    length;
   logic [7:0]    score;
   logic [XW-1:0] query_x;
   logic [YW-1:0] query_y;
   logic [1:0]    query_cell;

   modport master (
      output first_do, go_one_step, eat_apple, random_growth, dir_btn, query_x, query_y,
      input  head, head_x, head_y, apple_x, apple_y, apple_valid, length, score, query_cell
   );

   modport slave (
      input  first_do, go_one_step, eat_apple, random_growth, dir_btn, query_x, query_y,
      output head, head_x, head_y, apple_x, apple_y, apple_valid, length, score, query_cell
   );
endinterface

// File: rtl/snake_body_engine.sv
// Snake board datapath: body ring buffer, occupancy bitmap, apple seek, score, display query.
// Latency: pulse effects visible next cycle; head is combinational; query_cell 1 cycle.
// Backpressure: none; apple seek retries internally. WRAP_WALLS_EN makes the border playable.
module snake_body_engine #(
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 12,
   parameter int MAX_LEN = 32,
   parameter int START_X = 4,
   parameter int START_Y = 6
) (
   input logic clk2,
   input logic rst_n,
   snake_body_engine_if.slave bus
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int PW = $clog2(MAX_LEN);
   localparam int NC = GRID_W * GRID_H;
   localparam int CW = $clog2(NC);

   localparam logic [1:0] C_EMPTY = 2'b00;
   localparam logic [1:0] C_BODY  = 2'b01;
   localparam logic [1:0] C_APPLE = 2'b10;
   localparam logic [1:0] C_WALL  = 2'b11;

   localparam logic [3:0] D_UP    = 4'b1000;
   localparam logic [3:0] D_DOWN  = 4'b0100;
   localparam logic [3:0] D_LEFT  = 4'b0010;
   localparam logic [3:0] D_RIGHT = 4'b0001;

   typedef enum logic {S_IDLE, S_SEEK} seek_t;

   logic [XW-1:0] head_x, apple_x, nx, cand_x;
   logic [YW-1:0] head_y, apple_y, ny, cand_y;
   logic [NC-1:0] occ;
   logic [XW-1:0] body_x [MAX_LEN];
   logic [YW-1:0] body_y [MAX_LEN];
   logic [PW-1:0] hd_ptr, tl_ptr, hd_ptr_nxt, tl_ptr_nxt;
   logic [5:0]    length;
   logic [7:0]    score;
   logic [7:0]    lfsr;
   logic [3:0]    direction, pending_dir;
   logic          apple_valid;
   logic [1:0]    head_cls, cand_cls, query_cell;
   logic          dir_ok, step_move, step_grow, seek_ok, seek_accept;
   seek_t         seek_st, seek_nxt;

   function automatic logic [3:0] opposite(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

   function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return CW'(int'(y) * GRID_W + int'(x));
   endfunction

   // Class of any cell against current board state; the head cell is in the bitmap, so it reads as body.
   function automatic logic [1:0] classify(input logic [XW-1:0] x, input logic [YW-1:0] y);
`ifdef WRAP_WALLS_EN
      if (int'(x) >= GRID_W || int'(y) >= GRID_H) return C_EMPTY;
`else
      if (int'(x) == 0 || int'(x) >= GRID_W - 1 || int'(y) == 0 || int'(y) >= GRID_H - 1) return C_WALL;
`endif
      if (occ[cell_idx(x, y)]) return C_BODY;
      if (apple_valid && x == apple_x && y == apple_y) return C_APPLE;
      return C_EMPTY;
   endfunction

   assign hd_ptr_nxt = (int'(hd_ptr) == MAX_LEN - 1) ? '0 : hd_ptr + 1'b1;
   assign tl_ptr_nxt = (int'(tl_ptr) == MAX_LEN - 1) ? '0 : tl_ptr + 1'b1;
   assign cand_x     = XW'(lfsr[3:0]);
   assign cand_y     = YW'(lfsr[7:4]);
   assign dir_ok     = $onehot(bus.dir_btn) && (bus.dir_btn != opposite(direction));

   // Next head cell from the pending direction; edges wrap, which only matters when the border is playable.
   always_comb begin
      nx = head_x;
      ny = head_y;
      case (pending_dir)
         D_UP:    ny = (head_y == '0) ? YW'(GRID_H - 1) : head_y - 1'b1;
         D_DOWN:  ny = (int'(head_y) == GRID_H - 1) ? '0 : head_y + 1'b1;
         D_LEFT:  nx = (head_x == '0) ? XW'(GRID_W - 1) : head_x - 1'b1;
         D_RIGHT: nx = (int'(head_x) == GRID_W - 1) ? '0 : head_x + 1'b1;
         default: ;
      endcase
   end

   // Classify the cell ahead and decide whether a step moves and/or grows the body.
   always_comb begin
      head_cls  = (length == '0) ? C_EMPTY : classify(nx, ny);
      step_move = bus.go_one_step && !bus.first_do && (length != '0) && !head_cls[0];
      step_grow = step_move && (head_cls == C_APPLE) && (int'(length) < MAX_LEN);
   end

   // Apple candidate check: on the playable area, free, and not where the head goes next.
   always_comb begin
      cand_cls = classify(cand_x, cand_y);
      seek_ok  = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H) && !cand_cls[0]
                 && !((cand_x == nx) && (cand_y == ny));
   end

   // Seek FSM state register.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) seek_st <= S_IDLE;
      else        seek_st <= seek_nxt;
   end

   // Seek FSM next state; board init aborts a seek, a step in the same cycle blocks a new one.
   always_comb begin
      seek_nxt = seek_st;
      if (bus.first_do) seek_nxt = S_IDLE;
      else begin
         case (seek_st)
            S_IDLE:  if (bus.random_growth && !bus.go_one_step) seek_nxt = S_SEEK;
            S_SEEK:  if (seek_ok) seek_nxt = S_IDLE;
            default: seek_nxt = S_IDLE;
         endcase
      end
   end

   // Seek FSM output: load the candidate as the new apple.
   always_comb seek_accept = (seek_st == S_SEEK) && seek_ok && !bus.first_do;

   // Ring buffer storage; positions need no reset since length gates every read.
   always_ff @(posedge clk2) begin
      if (bus.first_do) begin
         for (int i = 0; i < 3; i++) begin
            body_x[i] <= XW'(START_X - 2 + i);
            body_y[i] <= YW'(START_Y);
         end
      end else if (step_move) begin
         body_x[hd_ptr_nxt] <= nx;
         body_y[hd_ptr_nxt] <= ny;
      end
   end

   // Board state: pointers, bitmap, head, apple, direction, score, LFSR and the query register.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         occ         <= '0;
         hd_ptr      <= '0;
         tl_ptr      <= '0;
         length      <= '0;
         head_x      <= '0;
         head_y      <= '0;
         apple_x     <= '0;
         apple_y     <= '0;
         apple_valid <= 1'b0;
         score       <= '0;
         direction   <= D_RIGHT;
         pending_dir <= D_RIGHT;
         lfsr        <= 8'hA5;
         query_cell  <= C_EMPTY;
      end else begin
         lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         query_cell <= classify(bus.query_x, bus.query_y);
         if (bus.eat_apple && score != 8'hFF) score <= score + 8'd1;
         if (bus.first_do) begin
            occ <= '0;
            for (int i = 0; i < 3; i++) occ[cell_idx(XW'(START_X - 2 + i), YW'(START_Y))] <= 1'b1;
            tl_ptr      <= '0;
            hd_ptr      <= PW'(2);
            length      <= 6'd3;
            head_x      <= XW'(START_X);
            head_y      <= YW'(START_Y);
            direction   <= D_RIGHT;
            pending_dir <= D_RIGHT;
            apple_x     <= XW'(GRID_W - 4);
            apple_y     <= YW'(START_Y);
            apple_valid <= 1'b1;
            score       <= '0;
         end else begin
            if (dir_ok) pending_dir <= bus.dir_btn;
            if (bus.go_one_step) direction <= pending_dir;
            if (step_move) begin
               head_x              <= nx;
               head_y              <= ny;
               hd_ptr              <= hd_ptr_nxt;
               occ[cell_idx(nx, ny)] <= 1'b1;
               if (step_grow) begin
                  length      <= length + 6'd1;
                  apple_valid <= 1'b0;
               end else begin
                  occ[cell_idx(body_x[tl_ptr], body_y[tl_ptr])] <= 1'b0;
                  tl_ptr <= tl_ptr_nxt;
               end
            end
            // A freshly placed apple wins over one eaten in the same cycle.
            if (seek_accept) begin
               apple_x     <= cand_x;
               apple_y     <= cand_y;
               apple_valid <= 1'b1;
            end
         end
      end
   end

   assign bus.head        = head_cls;
   assign bus.head_x      = head_x;
   assign bus.head_y      = head_y;
   assign bus.apple_x     = apple_x;
   assign bus.apple_y     = apple_y;
   assign bus.apple_valid = apple_valid;
   assign bus.length      = length;
   assign bus.score       = score;
   assign bus.query_cell  = query_cell;
endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Board/body datapath for the snake game; sits directly downstream of the game control FSM.
- Consumes its one-cycle action pulses: first_do, go_one_step, eat_apple, random_growth.
- Returns the 2-bit classification of the cell ahead of the snake head, which the FSM uses for its next branch.
- Also holds the body ring buffer, occupancy bitmap, apple position and score, and answers per-cell queries from the display.

Parameters:
- GRID_W, 16, board width in cells; x = 0..GRID_W-1.
- GRID_H, 12, board height in cells; y = 0..GRID_H-1.
- MAX_LEN, 32, body ring-buffer depth.
- START_X, 4, initial head x; START_Y, 6, initial head y.

Ports:
- clk2  in  1  game clock.
- rst_n  in  1  asynchronous active-low reset.
- first_do  in  1  pulse: initialise board.
- go_one_step  in  1  pulse: commit one move.
- eat_apple  in  1  pulse: score increment.
- random_growth  in  1  pulse: relocate apple.
- dir_btn  in  4  one-hot {up,down,left,right}, level.
- head  out  2  class of next cell: 00 empty, 01 body, 10 apple, 11 wall.
- head_x, head_y  out  clog2(GRID_W)/clog2(GRID_H)  current head cell.
- apple_x, apple_y  out  same widths  apple cell.
- apple_valid  out  1  apple placed.
- length  out  6  body length in cells.
- score  out  8  apples eaten.
- query_x, query_y  in  coordinate widths  display cell address.
- query_cell  out  2  class of the queried cell, same encoding as head, registered.

Behaviour:
- Reset (async, rst_n=0):
  - Body empty, length=0; direction=right, pending_dir=right.
  - head_x=head_y=0, apple_x=apple_y=0, apple_valid=0, score=0.
  - LFSR=8'hA5; seek FSM=IDLE; query_cell=00.
  - Occupancy bitmap cleared.
- Reset mid-seek or mid-game discards all state; no pulse is remembered.
- Direction input, sampled every cycle:
  - A single-hot dir_btn updates pending_dir.
  - Zero-hot or multi-hot input is ignored.
  - A request opposite to the committed direction is ignored.
- head output (combinational from registered state):
  - Next cell = head + committed-or-pending direction; pending is used.
  - Wall (11) when the next cell is outside the board or on the border row/column.
  - Otherwise body (01) if occupied, including the current tail cell.
  - Otherwise apple (10) if equal to the apple cell and apple_valid=1.
  - Otherwise empty (00).
  - When length=0, head=00.
- first_do (1 cycle):
  - Clear the bitmap.
  - Load body (START_X-2,START_Y), (START_X-1,START_Y), (START_X,START_Y); length=3.
  - direction=pending_dir=right; apple=(GRID_W-4,START_Y), apple_valid=1; score=0; seek FSM=IDLE.
- go_one_step:
  - Commit pending_dir to direction.
  - If head class is 11 or 01: no body change.
  - Otherwise push the next cell as the new head and set its bitmap bit.
  - Pop the tail and clear its bit unless class=10 and length<MAX_LEN; in that case length+1 and apple_valid=0.
  - At MAX_LEN the tail always pops.
  - All updates are visible on head/head_x/length the following cycle.
- eat_apple: score+1, saturating at 255.
- random_growth: seek FSM IDLE->SEEK.
  - Each SEEK cycle, candidate x=LFSR[3:0] mod-free, y=LFSR[7:4].
  - Accept if interior, not occupied, and not the next head cell: load apple, apple_valid=1, go to IDLE.
  - Otherwise retry next cycle.
  - LFSR advances every cycle; taps x^8+x^6+x^5+x^4+1.
- Simultaneous pulses: priority first_do > go_one_step > random_growth; eat_apple is independent.
- Ring buffer: head/tail pointers wrap at MAX_LEN-1 to 0.
- query_cell: registered, 1-cycle latency. Reports wall/body/apple/empty for query_x, query_y; the head cell reads as body.

Optional Feature:
- WRAP_WALLS_EN defined:
  - Border cells are playable; leaving the board wraps x to 0/GRID_W-1 and y likewise.
  - Wall is never reported.
  - Apple candidates may lie on the border.
- Undefined: border and outside cells are wall, as described above.

Test Plan:
- Reset, first_do -> length=3, head_x=4, head_y=6, apple=(12,6), apple_valid=1, head=00.
- first_do, 7×go_one_step -> 8th step head=10. go_one_step, eat_apple -> length=4, score=1, apple_valid=0.
- random_growth with bitmap nearly full -> apple_valid rises only on a free interior cell; never on body.
- dir_btn=left while moving right -> ignored, head_x keeps incrementing. dir_btn=0b1001 -> ignored.
- Drive right to x=14 -> head=11; go_one_step leaves the body unchanged. With WRAP_WALLS_EN, x=15 -> next step head_x=0.
- Loop up/left/down to hit own body -> head=01; rst_n low mid-SEEK -> all outputs reset values immediately.
